bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one input bit per clock. It sits between binary measurement/counter sources and character displays (LCD/7-segment drivers). It produces packed BCD, per-digit ASCII and an overflow flag. Conversions start on an explicit handshake or from an optional internal periodic refresh tick.

## Interface
- WIDTH, 12 — binary input width in bits, ≥ 2.
- DIGITS, 4 — number of BCD digits produced, ≥ 1.
- REFRESH, 12_500_000 — auto-start period in clk cycles; 0 disables auto-start. Must be 0 or ≥ WIDTH+2.
- clk  in  1 — single clock, all logic on rising edge.
- rst_n  in  1 — asynchronous, active-low reset.
- start  in  1 — request a conversion; sampled only in IDLE.
- numero  in  WIDTH — unsigned binary value, captured on the accepted start.
- busy  out  1 — high from the cycle after acceptance until the cycle done is asserted.
- done  out  1 — one-cycle pulse; outputs valid and updated on this edge.
- bcd  out  4*DIGITS — packed BCD, digit 0 (units) in bits [3:0].
- ascii  out  8*DIGITS — per-digit ASCII, digit k in bits [8k+7:8k].
- overflow  out  1 — last result exceeded 10^DIGITS − 1.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: on trigger = start OR refresh tick:
  - capture numero into the shift register;
  - clear the BCD scratch and the overflow scratch;
  - load the bit counter with WIDTH;
  - go to SHIFT.
- SHIFT, one bit per cycle:
  - add 3 to every scratch digit ≥ 5;
  - shift {scratch, shift register} left by one;
  - if the bit shifted out of the top digit is 1, set the overflow scratch (sticky);
  - decrement the counter; at 1, go to DONE.
- DONE, for one cycle:
  - register bcd, ascii and overflow; pulse done; go to IDLE.
  - If the overflow scratch is set, bcd = all digits 9 and ascii = all '9' (saturate).
  - Otherwise, ascii digit = BCD digit + 8'd48.
- Refresh counter: counts 0..REFRESH−1 continuously and wraps; the tick fires when it reaches REFRESH−1.
  - A tick occurring outside IDLE is dropped, not queued.
  - start and a tick in the same IDLE cycle produce one conversion, using numero from that cycle.
- start asserted while busy is ignored. numero changes during a conversion have no effect.
- Outputs hold their last value between done pulses.

## Timing
- Reset values:
  - busy = 0, done = 0, overflow = 0;
  - bcd = 0;
  - ascii = all 8'h30 (blanking variant: 8'h20 except the units digit, which is 8'h30);
  - FSM in IDLE; refresh counter = 0.
- Latency: trigger sampled on edge 0; busy high after edge 0; done high and outputs valid after edge WIDTH+1; busy low after edge WIDTH+1.
- Throughput: one conversion per WIDTH+2 cycles with start held high continuously.
- Reset mid-conversion:
  - the conversion is abandoned immediately and all outputs return to their reset values;
  - no done pulse is issued;
  - the refresh counter restarts from 0.
- Arithmetic: scratch width is 4*DIGITS bits. The add-3 on a digit is 4-bit and never carries into the next digit, because digits ≤ 9 before correction. Overflow detection relies only on the top-digit shift-out.

## Configuration
- BIN2BCD_BLANK_EN defined:
  - leading-zero blanking on ascii: every zero digit more significant than the highest nonzero digit is driven as 8'h20 (space);
  - the units digit is always shown;
  - saturated results are never blanked;
  - bcd is unaffected.
- BIN2BCD_BLANK_EN undefined: every ascii digit = BCD + 8'd48; no blanking logic is synthesised.

## Test plan
- WIDTH=12, DIGITS=4, REFRESH=0; start with numero=4095 -> done exactly 13 cycles after start is sampled; bcd=16'h4095; ascii="4095"; overflow=0.
- numero=0 -> bcd=0, ascii="0000" (blanking: "   0"); numero=7 with blanking -> "   7"; numero=1000 with blanking -> "1000".
- DIGITS=3, numero=1000 -> overflow=1, bcd=12'h999, ascii="999"; then numero=999 -> overflow=0, bcd=12'h999.
- Pulse start with numero=1234, then pulse start with numero=42 while busy -> single done, bcd=16'h1234; a later start with 42 -> 16'h0042.
- Deassert rst_n during SHIFT -> busy=0, bcd=0, ascii at reset pattern, no done pulse; after release a fresh start converts correctly.
- REFRESH=20, start tied low, numero=321 -> done pulses every 20 cycles, first at cycle 19+13; bcd=16'h0321; ticks coinciding with busy are dropped.

Source files
------------

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential binary-to-BCD converter (shift-and-add-3), one
//               input bit per clock. Produces packed BCD, per-digit ASCII and
//               a saturating overflow flag. Conversions start on a start
//               handshake or on an optional periodic refresh tick.
//               Optional feature macro: BIN2BCD_BLANK_EN (leading-zero
//               blanking of the ASCII output).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int WIDTH   = 12,
    parameter int DIGITS  = 4,
    parameter int REFRESH = 12_500_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      numero,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [8*DIGITS-1:0]   ascii,
    output logic                  overflow
);

    localparam int c_SW = 4 * DIGITS;
    localparam int c_AW = 8 * DIGITS;
    localparam int c_CW = $clog2(WIDTH + 1);

`ifdef BIN2BCD_BLANK_EN
    // Upper digits show as space, units digit as '0'
    localparam logic [c_AW-1:0] c_ASCII_RST = {DIGITS{8'h20}} | c_AW'(8'h10);
`else
    localparam logic [c_AW-1:0] c_ASCII_RST = {DIGITS{8'h30}};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [c_SW-1:0]    scratch_q, scratch_d;
    logic               ovf_scr_q, ovf_scr_d;
    logic [c_CW-1:0]    cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [c_SW-1:0]    bcd_q, bcd_d;
    logic [c_AW-1:0]    ascii_q, ascii_d;
    logic               overflow_q, overflow_d;

    logic               w_tick;
    logic [c_SW-1:0]    w_corr;
    logic [c_SW-1:0]    w_res_bcd;
    logic [c_AW-1:0]    w_res_ascii;

    // ------------------------------------------------------------------
    // Periodic refresh tick; absent entirely when REFRESH is zero
    // ------------------------------------------------------------------
    generate
        if (REFRESH > 0) begin : g_refresh
            localparam int c_RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
            logic [c_RW-1:0] ref_cnt_q, ref_cnt_d;

            // Free-running 0..REFRESH-1 counter
            always_comb begin
                if (ref_cnt_q == c_RW'(REFRESH - 1)) begin
                    ref_cnt_d = '0;
                end else begin
                    ref_cnt_d = ref_cnt_q + c_RW'(1);
                end
            end

            // Counter register, restarts from zero on reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ref_cnt_q <= '0;
                end else begin
                    ref_cnt_q <= ref_cnt_d;
                end
            end

            assign w_tick = (ref_cnt_q == c_RW'(REFRESH - 1));
        end else begin : g_no_refresh
            assign w_tick = 1'b0;
        end
    endgenerate

    // Add-3 correction on each digit >= 5; digits never exceed 9 so no carry
    always_comb begin
        w_corr = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) begin
                w_corr[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
            end else begin
                w_corr[4*k +: 4] = scratch_q[4*k +: 4];
            end
        end
    end

    // Final result formatting: saturation, ASCII and optional blanking
`ifdef BIN2BCD_BLANK_EN
    logic w_lead;
`endif
    always_comb begin
        w_res_bcd   = ovf_scr_q ? {DIGITS{4'h9}} : scratch_q;
        w_res_ascii = '0;
        for (int k = 0; k < DIGITS; k++) begin
            w_res_ascii[8*k +: 8] = {4'h3, w_res_bcd[4*k +: 4]};
        end
`ifdef BIN2BCD_BLANK_EN
        // Saturated value is all nines, so it is naturally never blanked
        w_lead = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (w_lead && (w_res_bcd[4*k +: 4] == 4'd0)) begin
                w_res_ascii[8*k +: 8] = 8'h20;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
    end

    // Next-state logic for the IDLE/SHIFT/DONE sequencer and datapath
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        ovf_scr_d  = ovf_scr_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_d      = bcd_q;
        ascii_d    = ascii_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                // A tick and start together still give a single conversion
                if (start || w_tick) begin
                    shift_d   = numero;
                    scratch_d = '0;
                    ovf_scr_d = 1'b0;
                    cnt_d     = c_CW'(WIDTH);
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scratch_d = {w_corr[c_SW-2:0], shift_q[WIDTH-1]};
                shift_d   = {shift_q[WIDTH-2:0], 1'b0};
                if (w_corr[c_SW-1]) begin
                    ovf_scr_d = 1'b1;
                end
                cnt_d = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                bcd_d      = w_res_bcd;
                ascii_d    = w_res_ascii;
                overflow_d = ovf_scr_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any conversion in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            ovf_scr_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
            ascii_q    <= c_ASCII_RST;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            ovf_scr_q  <= ovf_scr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_q      <= bcd_d;
            ascii_q    <= ascii_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd      = bcd_q;
    assign ascii    = ascii_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Self-checking bench for bin2bcd_seq. Three instances: 4-digit,
//               3-digit (overflow/saturation) and 4-digit with REFRESH=20.
//               Honours BIN2BCD_BLANK_EN for ASCII expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        start    = 1'b0;
    logic [11:0] numero   = 12'd0;
    logic        start_r  = 1'b0;
    logic [11:0] numero_r = 12'd321;

    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [31:0] ascii;
    logic        busy3, done3, overflow3;
    logic [11:0] bcd3;
    logic [23:0] ascii3;
    logic        busy_r, done_r, overflow_r;
    logic [15:0] bcd_r;
    logic [31:0] ascii_r;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] bcd;
        logic [63:0] asc;
        logic        ovf;
    } exp_t;

    exp_t q4[$];
    exp_t q3[$];

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .REFRESH(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .numero(numero),
        .busy(busy), .done(done), .bcd(bcd), .ascii(ascii), .overflow(overflow)
    );

    bin2bcd_seq #(.WIDTH(12), .DIGITS(3), .REFRESH(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .numero(numero),
        .busy(busy3), .done(done3), .bcd(bcd3), .ascii(ascii3), .overflow(overflow3)
    );

    bin2bcd_seq #(.WIDTH(12), .DIGITS(4), .REFRESH(20)) dutr (
        .clk(clk), .rst_n(rst_n), .start(start_r), .numero(numero_r),
        .busy(busy_r), .done(done_r), .bcd(bcd_r), .ascii(ascii_r), .overflow(overflow_r)
    );

    // Decimal reference model (division based, independent of double-dabble)
    function automatic exp_t model(input int n, input int digits);
        exp_t e;
        int   lim;
        int   v;
        int   dig;
`ifdef BIN2BCD_BLANK_EN
        bit   lead;
`endif
        e   = '0;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.ovf = (n >= lim);
        v = n;
        for (int k = 0; k < digits; k++) begin
            dig = e.ovf ? 9 : (v % 10);
            v   = v / 10;
            e.bcd[4*k +: 4] = 4'(dig);
            e.asc[8*k +: 8] = 8'(48 + dig);
        end
`ifdef BIN2BCD_BLANK_EN
        lead = !e.ovf;
        for (int k = digits - 1; k >= 1; k--) begin
            if (lead && (e.bcd[4*k +: 4] == 4'd0)) e.asc[8*k +: 8] = 8'h20;
            else lead = 1'b0;
        end
`endif
        return e;
    endfunction

    function automatic logic [63:0] reset_ascii(input int digits);
        logic [63:0] a;
        a = '0;
        for (int k = 0; k < digits; k++) begin
`ifdef BIN2BCD_BLANK_EN
            a[8*k +: 8] = (k == 0) ? 8'h30 : 8'h20;
`else
            a[8*k +: 8] = 8'h30;
`endif
        end
        return a;
    endfunction

    task automatic pulse_start(input int n, input bit track);
        @(negedge clk);
        numero = 12'(n);
        start  = 1'b1;
        if (track) begin
            q4.push_back(model(n, 4));
            q3.push_back(model(n, 3));
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [63:0] r4, r3;
        r4 = reset_ascii(4);
        r3 = reset_ascii(3);
        #2 rst_n = 1'b0;
        #20;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        total++; if (bcd !== 16'h0) begin bad++; $display("FAIL reset_bcd got=%h exp=0000", bcd); end
        total++; if (ascii !== r4[31:0]) begin bad++; $display("FAIL reset_ascii got=%h exp=%h", ascii, r4[31:0]); end
        total++; if (ascii3 !== r3[23:0]) begin bad++; $display("FAIL reset_ascii3 got=%h exp=%h", ascii3, r3[23:0]); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_conversions;
        int   vals[8] = '{4095, 0, 7, 1000, 999, 5, 2048, 90};
        int   lat;
        exp_t e4, e3;
        foreach (vals[i]) begin
            pulse_start(vals[i], 1'b1);
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL conv_busy n=%0d got=%b exp=1", vals[i], busy); end
            wait_done(lat);
            total++; if (lat != 13) begin bad++; $display("FAIL conv_latency n=%0d got=%0d exp=13", vals[i], lat); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL conv_busy_end n=%0d got=%b exp=0", vals[i], busy); end
            total++; if (done3 !== 1'b1) begin bad++; $display("FAIL conv_done3 n=%0d got=%b exp=1", vals[i], done3); end
            e4 = q4.pop_front();
            e3 = q3.pop_front();
            total++; if (bcd !== e4.bcd[15:0]) begin bad++; $display("FAIL conv_bcd n=%0d got=%h exp=%h", vals[i], bcd, e4.bcd[15:0]); end
            total++; if (ascii !== e4.asc[31:0]) begin bad++; $display("FAIL conv_ascii n=%0d got=%h exp=%h", vals[i], ascii, e4.asc[31:0]); end
            total++; if (overflow !== e4.ovf) begin bad++; $display("FAIL conv_ovf n=%0d got=%b exp=%b", vals[i], overflow, e4.ovf); end
            total++; if (bcd3 !== e3.bcd[11:0]) begin bad++; $display("FAIL conv_bcd3 n=%0d got=%h exp=%h", vals[i], bcd3, e3.bcd[11:0]); end
            total++; if (ascii3 !== e3.asc[23:0]) begin bad++; $display("FAIL conv_ascii3 n=%0d got=%h exp=%h", vals[i], ascii3, e3.asc[23:0]); end
            total++; if (overflow3 !== e3.ovf) begin bad++; $display("FAIL conv_ovf3 n=%0d got=%b exp=%b", vals[i], overflow3, e3.ovf); end
            @(posedge clk);
            #1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL conv_done_pulse n=%0d got=%b exp=0", vals[i], done); end
            total++; if (bcd !== e4.bcd[15:0]) begin bad++; $display("FAIL conv_hold n=%0d got=%h exp=%h", vals[i], bcd, e4.bcd[15:0]); end
        end
    endtask

    task automatic test_busy_ignore;
        int   lat;
        int   extra;
        exp_t e4, e3;
        pulse_start(1234, 1'b1);
        repeat (3) @(posedge clk);
        pulse_start(42, 1'b0);
        wait_done(lat);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL busy_done got=%b exp=1", done); end
        e4 = q4.pop_front();
        e3 = q3.pop_front();
        total++; if (bcd !== e4.bcd[15:0]) begin bad++; $display("FAIL busy_bcd got=%h exp=%h", bcd, e4.bcd[15:0]); end
        total++; if (bcd3 !== e3.bcd[11:0]) begin bad++; $display("FAIL busy_bcd3 got=%h exp=%h", bcd3, e3.bcd[11:0]); end
        total++; if (overflow3 !== e3.ovf) begin bad++; $display("FAIL busy_ovf3 got=%b exp=%b", overflow3, e3.ovf); end
        extra = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL busy_extra_done got=%0d exp=0", extra); end
        pulse_start(42, 1'b1);
        wait_done(lat);
        e4 = q4.pop_front();
        e3 = q3.pop_front();
        total++; if (lat != 13) begin bad++; $display("FAIL busy_42_latency got=%0d exp=13", lat); end
        total++; if (bcd !== e4.bcd[15:0]) begin bad++; $display("FAIL busy_42_bcd got=%h exp=%h", bcd, e4.bcd[15:0]); end
        total++; if (ascii !== e4.asc[31:0]) begin bad++; $display("FAIL busy_42_ascii got=%h exp=%h", ascii, e4.asc[31:0]); end
    endtask

    task automatic test_reset_mid;
        int          lat;
        int          extra;
        exp_t        e4, e3;
        logic [63:0] r4;
        r4 = reset_ascii(4);
        pulse_start(1234, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
        total++; if (bcd !== 16'h0) begin bad++; $display("FAIL mid_bcd got=%h exp=0000", bcd); end
        total++; if (ascii !== r4[31:0]) begin bad++; $display("FAIL mid_ascii got=%h exp=%h", ascii, r4[31:0]); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf got=%b exp=0", overflow); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        total++; if (extra != 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", extra); end
        pulse_start(777, 1'b1);
        wait_done(lat);
        e4 = q4.pop_front();
        e3 = q3.pop_front();
        total++; if (lat != 13) begin bad++; $display("FAIL mid_after_latency got=%0d exp=13", lat); end
        total++; if (bcd !== e4.bcd[15:0]) begin bad++; $display("FAIL mid_after_bcd got=%h exp=%h", bcd, e4.bcd[15:0]); end
        total++; if (ascii3 !== e3.asc[23:0]) begin bad++; $display("FAIL mid_after_ascii3 got=%h exp=%h", ascii3, e3.asc[23:0]); end
    endtask

    task automatic test_back_to_back;
        int   e;
        int   hits[$];
        exp_t x;
        @(negedge clk);
        numero = 12'd100;
        start  = 1'b1;
        q4.push_back(model(100, 4));
        q4.push_back(model(100, 4));
        e = -1;
        while (hits.size() < 2 && e < 60) begin
            @(posedge clk);
            #1;
            e++;
            if (done === 1'b1) begin
                hits.push_back(e);
                x = q4.pop_front();
                total++; if (bcd !== x.bcd[15:0]) begin bad++; $display("FAIL b2b_bcd got=%h exp=%h", bcd, x.bcd[15:0]); end
            end
        end
        start = 1'b0;
        total++;
        if (hits.size() != 2) begin
            bad++; $display("FAIL b2b_count got=%0d exp=2", hits.size());
        end else if (hits[0] != 13 || hits[1] != 27) begin
            bad++; $display("FAIL b2b_timing got=%0d,%0d exp=13,27", hits[0], hits[1]);
        end
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic test_refresh;
        int   e;
        int   hits[$];
        exp_t x;
        x = model(321, 4);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e = -1;
        while (hits.size() < 3 && e < 120) begin
            @(posedge clk);
            #1;
            e++;
            if (done_r === 1'b1) begin
                hits.push_back(e);
                total++; if (bcd_r !== x.bcd[15:0]) begin bad++; $display("FAIL refresh_bcd got=%h exp=%h", bcd_r, x.bcd[15:0]); end
                total++; if (ascii_r !== x.asc[31:0]) begin bad++; $display("FAIL refresh_ascii got=%h exp=%h", ascii_r, x.asc[31:0]); end
                total++; if (overflow_r !== 1'b0) begin bad++; $display("FAIL refresh_ovf got=%b exp=0", overflow_r); end
            end
        end
        total++;
        if (hits.size() != 3) begin
            bad++; $display("FAIL refresh_count got=%0d exp=3", hits.size());
        end else if (hits[0] != 32 || hits[1] != 52 || hits[2] != 72) begin
            bad++; $display("FAIL refresh_timing got=%0d,%0d,%0d exp=32,52,72", hits[0], hits[1], hits[2]);
        end
    endtask

    initial begin
        test_reset();
        test_conversions();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_refresh();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
